// File: rtl/grf_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// grf_hazard_ctrl
//
// Hazard scheduler for a 5-stage MIPS pipeline (F/D/E/M/W). The block keeps
// a shadow record of every in-flight GRF producer in E, M and W (destination,
// write enable, cycles left until the result exists). It checks those
// records against the operands of the instruction sitting in D and produces:
//   * a D-stage stall when a needed value cannot be ready in time,
//   * forward-select codes for the D-stage and E-stage operand muxes.
// It also sequences the multi-cycle multiply/divide unit with a busy counter
// so that HI/LO accesses wait until the running operation has completed.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high; all records become bubbles
//   d_rs, d_rt    in   D-stage source registers
//   d_rs_use      in   D instruction reads rs
//   d_rt_use      in   D instruction reads rt
//   d_rs_tuse     in   cycles from D until rs is consumed (0 = used in D)
//   d_rt_tuse     in   same for rt
//   d_dst         in   destination register of the D instruction
//   d_wen         in   D instruction writes the GRF
//   d_tnew        in   cycles after entering E until its result exists
//   d_md_start    in   D instruction starts a mult/div
//   d_md_div      in   qualifies d_md_start: 1 = divide, 0 = multiply
//   d_md_use      in   D instruction touches HI/LO
//   flush         in   synchronous pipeline flush (E, M, W become bubbles)
//   stall         out  freeze F and D, bubble into E (combinational)
//   d_fwd_rs_sel  out  0 = GRF, 1 = from E, 2 = from M
//   d_fwd_rt_sel  out  same encoding
//   e_fwd_rs_sel  out  0 = E-latched value, 1 = from M, 2 = from W
//   e_fwd_rt_sel  out  same encoding
//   md_busy       out  mult/div busy counter is nonzero
//
// Handshake: there is no valid/ready pair here. The D instruction is taken
// into E on every edge where stall = 0 and flush = 0; while stall = 1 the
// upstream stages must hold the D instruction unchanged.
// ---------------------------------------------------------------------------
module grf_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int TW          = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic          d_rs_use,
    input  logic          d_rt_use,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic [4:0]    d_dst,
    input  logic          d_wen,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    d_fwd_rs_sel,
    output logic [1:0]    d_fwd_rt_sel,
    output logic [1:0]    e_fwd_rs_sel,
    output logic [1:0]    e_fwd_rt_sel,
    output logic          md_busy
);

    localparam logic [TW-1:0] TNEW_ZERO = '0;
    localparam logic [TW-1:0] TNEW_ONE  = TW'(1);

    localparam logic [1:0] D_SEL_GRF = 2'd0;
    localparam logic [1:0] D_SEL_E   = 2'd1;
    localparam logic [1:0] D_SEL_M   = 2'd2;
    localparam logic [1:0] E_SEL_OWN = 2'd0;
    localparam logic [1:0] E_SEL_M   = 2'd1;
    localparam logic [1:0] E_SEL_W   = 2'd2;

    // ------------------------------------------------------------------
    // Stage records
    // ------------------------------------------------------------------
    // E stage: producer info plus the operands it will read in E.
    logic [4:0]    e_dst;
    logic          e_wen;
    logic [TW-1:0] e_tnew;
    logic [4:0]    e_rs;
    logic [4:0]    e_rt;
    logic          e_rs_use;
    logic          e_rt_use;

    // M stage.
    logic [4:0]    m_dst;
    logic          m_wen;
    logic [TW-1:0] m_tnew;

    // W stage. Its result always exists by W, so no tnew is kept for it.
    logic [4:0]    w_dst;
    logic          w_wen;

    // Mult/div busy countdown.
    logic [3:0]    md_cnt;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // A stage supplies register r only if it writes and r is not $0.
    function automatic logic match(input logic       wen,
                                   input logic [4:0] dst,
                                   input logic [4:0] r);
        return wen && (dst == r) && (r != 5'd0);
    endfunction

    // D-stage select: the youngest matching stage decides. If that stage
    // is still computing, the GRF path is selected; the stall logic makes
    // sure the operand is not consumed before the producer catches up.
    function automatic logic [1:0] d_sel(input logic [4:0] r);
        logic [1:0] sel;
        sel = D_SEL_GRF;
        if (match(e_wen, e_dst, r)) begin
            sel = (e_tnew == TNEW_ZERO) ? D_SEL_E : D_SEL_GRF;
        end else if (match(m_wen, m_dst, r) && (m_tnew == TNEW_ZERO)) begin
            sel = D_SEL_M;
        end
        return sel;
    endfunction

    // E-stage select for an operand latched into E.
    function automatic logic [1:0] e_sel(input logic       used,
                                         input logic [4:0] r);
        logic [1:0] sel;
        sel = E_SEL_OWN;
        if (used && match(m_wen, m_dst, r) && (m_tnew == TNEW_ZERO)) begin
            sel = E_SEL_M;
        end else if (used && match(w_wen, w_dst, r)) begin
            sel = E_SEL_W;
        end
        return sel;
    endfunction

    // Stall for one D operand: a producer in E or M will not have its
    // result in time for the operand's deadline. W is covered by the
    // GRF write-through and never stalls.
    function automatic logic operand_stall(input logic          used,
                                           input logic [4:0]    r,
                                           input logic [TW-1:0] tuse);
        logic hit_e;
        logic hit_m;
        hit_e = match(e_wen, e_dst, r) && (e_tnew > tuse);
        hit_m = match(m_wen, m_dst, r) && (m_tnew > tuse);
        return used && (hit_e || hit_m);
    endfunction

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic md_load;
    logic [TW-1:0] e_tnew_dec;

    always_comb begin
        stall_rs     = operand_stall(d_rs_use, d_rs, d_rs_tuse);
        stall_rt     = operand_stall(d_rt_use, d_rt, d_rt_tuse);
        stall_md     = d_md_use && (md_cnt != 4'd0);
        stall        = stall_rs || stall_rt || stall_md;

        d_fwd_rs_sel = d_sel(d_rs);
        d_fwd_rt_sel = d_sel(d_rt);
        e_fwd_rs_sel = e_sel(e_rs_use, e_rs);
        e_fwd_rt_sel = e_sel(e_rt_use, e_rt);

        md_busy      = (md_cnt != 4'd0);

        // A mult/div only starts when its instruction actually leaves D.
        md_load      = d_md_start && !stall && !flush;

        // Remaining latency saturates at zero as a record moves E -> M.
        e_tnew_dec   = (e_tnew == TNEW_ZERO) ? TNEW_ZERO : (e_tnew - TNEW_ONE);
    end

    // ------------------------------------------------------------------
    // Stage records: flush > stall > normal advance
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_dst    <= 5'd0;
            e_wen    <= 1'b0;
            e_tnew   <= TNEW_ZERO;
            e_rs     <= 5'd0;
            e_rt     <= 5'd0;
            e_rs_use <= 1'b0;
            e_rt_use <= 1'b0;
            m_dst    <= 5'd0;
            m_wen    <= 1'b0;
            m_tnew   <= TNEW_ZERO;
            w_dst    <= 5'd0;
            w_wen    <= 1'b0;
        end else if (flush) begin
            e_dst    <= 5'd0;
            e_wen    <= 1'b0;
            e_tnew   <= TNEW_ZERO;
            e_rs     <= 5'd0;
            e_rt     <= 5'd0;
            e_rs_use <= 1'b0;
            e_rt_use <= 1'b0;
            m_dst    <= 5'd0;
            m_wen    <= 1'b0;
            m_tnew   <= TNEW_ZERO;
            w_dst    <= 5'd0;
            w_wen    <= 1'b0;
        end else begin
            // M and W shift on every non-flush edge, stalled or not.
            m_dst    <= e_dst;
            m_wen    <= e_wen;
            m_tnew   <= e_tnew_dec;
            w_dst    <= m_dst;
            w_wen    <= m_wen;
            if (stall) begin
                // D holds; a bubble goes into E.
                e_dst    <= 5'd0;
                e_wen    <= 1'b0;
                e_tnew   <= TNEW_ZERO;
                e_rs     <= 5'd0;
                e_rt     <= 5'd0;
                e_rs_use <= 1'b0;
                e_rt_use <= 1'b0;
            end else begin
                e_dst    <= d_dst;
                e_wen    <= d_wen;
                e_tnew   <= d_tnew;
                e_rs     <= d_rs;
                e_rt     <= d_rt;
                e_rs_use <= d_rs_use;
                e_rt_use <= d_rt_use;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mult/div busy counter. A flush does not cancel a running operation:
    // it was already issued to the unit and will still complete.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (md_load) begin
            md_cnt <= d_md_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
module tb_grf_hazard_ctrl;

  localparam int TW = 2;
  localparam int MULT_N = 5;
  localparam int DIV_N = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] d_rs, d_rt, d_dst;
  logic d_rs_use, d_rt_use, d_wen;
  logic [TW-1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic d_md_start, d_md_div, d_md_use, flush;
  logic stall, md_busy;
  logic [1:0] d_fwd_rs_sel, d_fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel;

  grf_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .TW(TW)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_dst(d_dst), .d_wen(d_wen), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .flush(flush), .stall(stall),
    .d_fwd_rs_sel(d_fwd_rs_sel), .d_fwd_rt_sel(d_fwd_rt_sel),
    .e_fwd_rs_sel(e_fwd_rs_sel), .e_fwd_rt_sel(e_fwd_rt_sel),
    .md_busy(md_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, dst;
    logic rs_use, rt_use, wen;
    logic [TW-1:0] rs_tuse, rt_tuse, tnew;
    logic md_start, md_div, md_use, flush;
  } din_t;

  typedef struct {
    logic stall;
    logic [1:0] drs, drt, ers, ert;
    logic busy;
  } dout_t;

  typedef struct {
    din_t in;
    dout_t exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------------------
  // reference model: list of issued instructions stamped with the cycle
  // they entered E; stage = age in cycles since then.
  // ------------------------------------------------------------------
  typedef struct {
    logic [4:0] dst, rs, rt;
    logic wen;
    int tnew;
    int ecyc;
  } inst_t;

  inst_t fl[$];
  int now = 0;
  int md_done = 0;

  function automatic void model_reset();
    fl.delete();
    now = 0;
    md_done = 0;
  endfunction

  function automatic inst_t stage_at(int age, output bit ok);
    inst_t r;
    r = '{dst: 5'd0, rs: 5'd0, rt: 5'd0, wen: 1'b0, tnew: 0, ecyc: 0};
    ok = 1'b0;
    foreach (fl[i]) begin
      if (now - fl[i].ecyc == age) begin
        r = fl[i];
        ok = 1'b1;
      end
    end
    return r;
  endfunction

  // cycles still needed at a given age; results always exist in W
  function automatic int remaining(inst_t s, int age);
    int v;
    v = s.tnew - age;
    if (age >= 2 || v < 0) v = 0;
    return v;
  endfunction

  function automatic bit hit(bit ok, inst_t s, logic [4:0] r);
    return ok && s.wen && s.dst == r && r != 5'd0;
  endfunction

  function automatic dout_t model_eval(din_t d);
    dout_t o;
    inst_t s0, s1, s2;
    bit v0, v1, v2;
    int n0, n1;
    bit st;
    s0 = stage_at(0, v0);
    s1 = stage_at(1, v1);
    s2 = stage_at(2, v2);
    n0 = remaining(s0, 0);
    n1 = remaining(s1, 1);
    st = 1'b0;
    if (d.rs_use && ((hit(v0, s0, d.rs) && n0 > int'(d.rs_tuse)) ||
                     (hit(v1, s1, d.rs) && n1 > int'(d.rs_tuse)))) st = 1'b1;
    if (d.rt_use && ((hit(v0, s0, d.rt) && n0 > int'(d.rt_tuse)) ||
                     (hit(v1, s1, d.rt) && n1 > int'(d.rt_tuse)))) st = 1'b1;
    if (d.md_use && now < md_done) st = 1'b1;
    o.stall = st;
    o.drs = hit(v0, s0, d.rs) ? ((n0 == 0) ? 2'd1 : 2'd0)
          : (hit(v1, s1, d.rs) && n1 == 0) ? 2'd2 : 2'd0;
    o.drt = hit(v0, s0, d.rt) ? ((n0 == 0) ? 2'd1 : 2'd0)
          : (hit(v1, s1, d.rt) && n1 == 0) ? 2'd2 : 2'd0;
    o.ers = 2'd0;
    o.ert = 2'd0;
    if (v0) begin
      o.ers = (hit(v1, s1, s0.rs) && n1 == 0) ? 2'd1 : hit(v2, s2, s0.rs) ? 2'd2 : 2'd0;
      o.ert = (hit(v1, s1, s0.rt) && n1 == 0) ? 2'd1 : hit(v2, s2, s0.rt) ? 2'd2 : 2'd0;
    end
    o.busy = (now < md_done);
    return o;
  endfunction

  function automatic void model_advance(din_t d, bit st);
    inst_t n;
    if (d.flush) begin
      fl.delete();
    end else if (!st) begin
      n = '{dst: d.dst, rs: d.rs, rt: d.rt, wen: d.wen, tnew: int'(d.tnew), ecyc: now + 1};
      fl.push_back(n);
      if (d.md_start) md_done = now + 1 + (d.md_div ? DIV_N : MULT_N);
    end
    now++;
    while (fl.size() > 0 && now - fl[0].ecyc > 2) void'(fl.pop_front());
  endfunction

  // ------------------------------------------------------------------
  // drivers / checkers
  // ------------------------------------------------------------------
  function automatic din_t mk_in(int rs, int rsu, int rstu, int rt, int rtu, int rttu,
                                 int dst, int wen, int tnew);
    din_t d;
    d.rs = 5'(rs); d.rs_use = 1'(rsu); d.rs_tuse = TW'(rstu);
    d.rt = 5'(rt); d.rt_use = 1'(rtu); d.rt_tuse = TW'(rttu);
    d.dst = 5'(dst); d.wen = 1'(wen); d.tnew = TW'(tnew);
    d.md_start = 1'b0; d.md_div = 1'b0; d.md_use = 1'b0; d.flush = 1'b0;
    return d;
  endfunction

  function automatic dout_t mo(int st, int drs, int drt, int ers, int ert, int busy);
    dout_t o;
    o.stall = 1'(st); o.drs = 2'(drs); o.drt = 2'(drt);
    o.ers = 2'(ers); o.ert = 2'(ert); o.busy = 1'(busy);
    return o;
  endfunction

  task automatic drive(din_t d);
    d_rs = d.rs; d_rt = d.rt; d_rs_use = d.rs_use; d_rt_use = d.rt_use;
    d_rs_tuse = d.rs_tuse; d_rt_tuse = d.rt_tuse;
    d_dst = d.dst; d_wen = d.wen; d_tnew = d.tnew;
    d_md_start = d.md_start; d_md_div = d.md_div; d_md_use = d.md_use;
    flush = d.flush;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(string nm, dout_t e);
    chk({nm, ".stall"}, int'(stall), int'(e.stall));
    chk({nm, ".d_fwd_rs"}, int'(d_fwd_rs_sel), int'(e.drs));
    chk({nm, ".d_fwd_rt"}, int'(d_fwd_rt_sel), int'(e.drt));
    chk({nm, ".e_fwd_rs"}, int'(e_fwd_rs_sel), int'(e.ers));
    chk({nm, ".e_fwd_rt"}, int'(e_fwd_rt_sel), int'(e.ert));
    chk({nm, ".md_busy"}, int'(md_busy), int'(e.busy));
  endtask

  // one pipeline cycle: drive, check at negedge, advance model at posedge
  task automatic cycle(string nm, din_t d, dout_t e);
    dout_t m;
    drive(d);
    m = model_eval(d);
    @(negedge clk);
    check_out(nm, e);
    @(posedge clk);
    model_advance(d, m.stall);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_out("reset", mo(0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    model_reset();
  endtask

  vec_t tbl[17];

  initial begin
    din_t d;
    dout_t m;
    bit hold;

    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;

    // table: lw-use, branch-use, $0 writes, link forwarding, youngest wins
    tbl[0]  = '{mk_in(29,1,1, 0,0,0,  8,1,2), mo(0,0,0,0,0,0)};
    tbl[1]  = '{mk_in( 8,1,1, 1,1,1,  9,1,1), mo(1,0,0,0,0,0)};
    tbl[2]  = '{mk_in( 8,1,1, 1,1,1,  9,1,1), mo(0,0,0,0,0,0)};
    tbl[3]  = '{mk_in( 0,0,0, 0,0,0,  0,0,0), mo(0,0,0,2,0,0)};
    tbl[4]  = '{mk_in( 1,1,1, 2,1,1,  3,1,1), mo(0,0,0,0,0,0)};
    tbl[5]  = '{mk_in( 3,1,0, 0,1,0,  0,0,0), mo(1,0,0,0,0,0)};
    tbl[6]  = '{mk_in( 3,1,0, 0,1,0,  0,0,0), mo(0,2,0,0,0,0)};
    tbl[7]  = '{mk_in( 0,1,1, 0,0,0,  0,1,1), mo(0,0,0,2,0,0)};
    tbl[8]  = '{mk_in( 0,1,1, 0,1,1,  4,1,1), mo(0,0,0,0,0,0)};
    tbl[9]  = '{mk_in( 0,0,0, 0,0,0,  0,0,0), mo(0,0,0,0,0,0)};
    tbl[10] = '{mk_in( 0,0,0, 0,0,0, 31,1,0), mo(0,0,0,0,0,0)};
    tbl[11] = '{mk_in(31,1,0, 0,0,0,  0,0,0), mo(0,1,0,0,0,0)};
    tbl[12] = '{mk_in( 0,1,1,31,1,1,  5,1,1), mo(0,0,2,1,0,0)};
    tbl[13] = '{mk_in( 0,0,0, 0,0,0,  0,0,0), mo(0,0,0,0,2,0)};
    tbl[14] = '{mk_in( 0,1,1, 0,1,1,  6,1,1), mo(0,0,0,0,0,0)};
    tbl[15] = '{mk_in( 0,1,1, 0,0,0,  6,1,2), mo(0,0,0,0,0,0)};
    tbl[16] = '{mk_in( 6,1,2, 0,0,0,  0,0,0), mo(0,0,0,0,0,0)};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
    end

    // mult then mflo, then div then mflo
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 0) ? MULT_N : DIV_N;
      do_reset();
      d = mk_in(1, 1, 1, 2, 1, 1, 0, 0, 0);
      d.md_start = 1'b1; d.md_div = 1'(k); d.md_use = 1'b1;
      cycle("md_issue", d, mo(0, 0, 0, 0, 0, 0));
      d = mk_in(0, 0, 0, 0, 0, 0, 7, 1, 1);
      d.md_use = 1'b1;
      for (int i = 0; i < n; i++) begin
        cycle($sformatf("md%0d_wait%0d", k, i), d, mo(1, 0, 0, 0, 0, 1));
      end
      cycle($sformatf("md%0d_done", k), d, mo(0, 0, 0, 0, 0, 0));
    end

    // asynchronous reset in the middle of a load-use stall with mult busy
    do_reset();
    d = mk_in(1, 1, 1, 2, 1, 1, 0, 0, 0);
    d.md_start = 1'b1; d.md_use = 1'b1;
    cycle("rst_mult", d, mo(0, 0, 0, 0, 0, 0));
    cycle("rst_lw", mk_in(29, 1, 1, 0, 0, 0, 8, 1, 2), mo(0, 0, 0, 0, 0, 1));
    drive(mk_in(8, 1, 1, 1, 1, 1, 9, 1, 1));
    #1;
    check_out("rst_pre", mo(1, 0, 0, 0, 0, 1));
    reset = 1'b1;
    #1;
    check_out("rst_async", mo(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle("rst_after", mk_in(8, 1, 1, 1, 1, 1, 9, 1, 1), mo(0, 0, 0, 0, 0, 0));

    // flush with a load in M and its consumer in D, mult still running
    do_reset();
    d = mk_in(1, 1, 1, 2, 1, 1, 0, 0, 0);
    d.md_start = 1'b1; d.md_use = 1'b1;
    cycle("fl_mult", d, mo(0, 0, 0, 0, 0, 0));
    cycle("fl_lw", mk_in(29, 1, 1, 0, 0, 0, 8, 1, 2), mo(0, 0, 0, 0, 0, 1));
    cycle("fl_nop", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
    d = mk_in(8, 1, 0, 0, 0, 0, 0, 0, 0);
    d.flush = 1'b1;
    cycle("fl_cons", d, mo(1, 0, 0, 0, 0, 1));
    cycle("fl_after", mk_in(8, 1, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
    cycle("fl_cnt1", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 1));
    cycle("fl_cnt0", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0));

    // randomized run against the reference model
    do_reset();
    hold = 1'b0;
    d = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        d.rs_use = 1'($urandom_range(0, 1));
        d.rs = d.rs_use ? 5'($urandom_range(0, 3)) : 5'd0;
        d.rs_tuse = TW'($urandom_range(0, 2));
        d.rt_use = 1'($urandom_range(0, 1));
        d.rt = d.rt_use ? 5'($urandom_range(0, 3)) : 5'd0;
        d.rt_tuse = TW'($urandom_range(0, 2));
        d.dst = 5'($urandom_range(0, 3));
        d.wen = 1'($urandom_range(0, 1));
        d.tnew = TW'($urandom_range(0, 3));
        d.md_start = ($urandom_range(0, 15) == 0);
        d.md_div = 1'($urandom_range(0, 1));
        d.md_use = d.md_start | ($urandom_range(0, 7) == 0);
      end
      d.flush = ($urandom_range(0, 31) == 0);
      m = model_eval(d);
      cycle("rand", d, m);
      hold = m.stall && !d.flush;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_hazard_ctrl.md
Name: grf_hazard_ctrl

Overview:
- Hazard scheduler for the 5-stage MIPS pipeline (F/D/E/M/W) that shares the 32x32 general register file between in-flight producers and the consumer in D.
- Tracks destination register, write-enable and remaining result latency (Tnew) for the E, M and W stages internally.
- Compares those against the D-stage source operands and their use deadlines (Tuse); issues the D-stage stall and the forward-select codes for the D and E stages.
- Sequences the multi-cycle multiply/divide unit with a busy countdown so HI/LO accesses stall until the operation completes.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu
- DIV_CYCLES, 10, busy cycles loaded for div/divu
- TW, 2, width of Tnew/Tuse fields

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all tracking state
- d_rs  in  5  D-stage source register 1
- d_rt  in  5  D-stage source register 2
- d_rs_use  in  1  D instruction reads rs
- d_rt_use  in  1  D instruction reads rt
- d_rs_tuse  in  TW  cycles from D until rs is consumed (0 = branch compare in D)
- d_rt_tuse  in  TW  same, for rt
- d_dst  in  5  destination register of the D instruction
- d_wen  in  1  D instruction writes GRF
- d_tnew  in  TW  cycles after entering E until the result exists (ALU=1, load=2, link=0)
- d_md_start  in  1  D instruction starts a mult/div
- d_md_div  in  1  qualifies d_md_start: 1 = divide
- d_md_use  in  1  D instruction touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- flush  in  1  synchronous pipeline flush (exception/eret)
- stall  out  1  freeze F and D, insert bubble into E (combinational)
- d_fwd_rs_sel  out  2  0 = GRF, 1 = from E, 2 = from M
- d_fwd_rt_sel  out  2  same encoding
- e_fwd_rs_sel  out  2  0 = E-latched value, 1 = from M, 2 = from W
- e_fwd_rt_sel  out  2  same encoding
- md_busy  out  1  busy counter nonzero

Behaviour:
- State: per stage S in {E, M, W}, a record {dst[4:0], wen, tnew[TW-1:0]}. E additionally holds rs/rt and their use flags. The block also holds md_cnt of 4 bits.
- A bubble is dst = 0, wen = 0, tnew = 0, use flags = 0.
- Reset (async): all records become bubbles and md_cnt = 0. Consequently stall = 0, md_busy = 0 and all fwd selects = 0 within the same cycle reset is asserted. Reset applied mid-stall drops stall immediately.
- Match(S, r): S.wen && S.dst == r && r != 0. Writes to $0 never match.
- Stall, per operand r with use flag set: stall if Match(E, r) && E.tnew > tuse_r, or Match(M, r) && M.tnew > tuse_r. W never causes a stall; GRF write-through covers W.
- MD stall: d_md_use && md_cnt != 0.
- stall is the OR of all stall terms.
- Advance each edge, with priority flush > stall > normal:
  - flush: E, M, W all become bubbles. md_cnt keeps counting because an issued mult/div still completes.
  - stall: E becomes a bubble; M <= E with tnew sat-decremented; W <= M with tnew = 0.
  - normal: E <= {d_dst, d_wen, d_tnew, operands}; M and W shift as above.
- md_cnt:
  - Loaded with MULT_CYCLES or DIV_CYCLES at an edge where d_md_start && !stall && !flush.
  - Otherwise decrements by 1 while nonzero.
  - Load wins over decrement.
- D forwarding, per operand r:
  - 1 if Match(E, r) && E.tnew == 0.
  - else 2 if Match(M, r) && M.tnew == 0.
  - else 0.
  - The youngest matching stage wins. If the youngest match has tnew != 0, the select is 0; the stall rule guarantees the value is not needed yet.
- E forwarding, per latched E operand r:
  - 1 if Match(M, r) && M.tnew == 0.
  - else 2 if Match(W, r).
  - else 0.
- Tnew saturates at 0. It is never negative and never wraps.

Test Plan:
- lw $8 (d_tnew=2) followed by add $9,$8,$1 (rs tuse=1): stall = 1 for exactly one cycle. The add then enters E. In the next cycle e_fwd_rs_sel = 2 (load in W).
- addu $3 (tnew=1) followed by beq $3,$0 (tuse=0): one stall cycle. Then d_fwd_rs_sel = 2 (from M); the branch proceeds with stall = 0.
- ori $0,$0,5 followed by addu $4,$0,$0: stall = 0, all fwd selects = 0.
- mult issued, then mflo in D the next cycle: md_busy = 1 and stall = 1 for 5 cycles. stall falls when md_cnt reaches 0. With DIV_CYCLES and div, the stall lasts 10 cycles.
- Load-use stall active when reset is asserted mid-cycle: stall, md_busy and all selects go to 0 before the next edge. After release, the first instruction issues with no stall.
- flush asserted while lw $8 is in M and the consumer is in D: the next cycle shows no match on $8. stall = 0, selects = 0; md_cnt keeps decrementing if it was running.
